// File: rtl/mist1032sa_mem_pkg.sv
// Shared memory-path definitions for the load aligner and store-side endian controller.
// Contents:
//   - byte-mask encodings (little-endian lane numbering, same on load and store paths)
//   - ld_attr_t: per-request attributes {mask, signed} held in the load queue
//   - ld_align(): lane extraction, byte swap, right-align and extension of a
//     big-endian memory word
package mist1032sa_mem_pkg;

  localparam logic [3:0] MASK_WORD    = 4'b1111;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_BYTE0   = 4'b0001;
  localparam logic [3:0] MASK_BYTE1   = 4'b0010;
  localparam logic [3:0] MASK_BYTE2   = 4'b0100;
  localparam logic [3:0] MASK_BYTE3   = 4'b1000;

  // Queue entry attributes; the tag travels alongside because its width is a
  // parameter of the user.
  typedef struct packed {
    logic [3:0] mask;
    logic       sgn;
  } ld_attr_t;

  // Memory word m is big-endian: little-endian lane 0 lives in m[7:0] but is
  // the most significant byte of a word load. Unknown masks fall back to lane 3.
  function automatic logic [31:0] ld_align(input logic [3:0]  mask,
                                           input logic        sgn,
                                           input logic [31:0] m);
    logic [31:0] r;
    r = '0;
    case (mask)
      MASK_WORD:    r = {m[7:0], m[15:8], m[23:16], m[31:24]};
      MASK_HALF_LO: r = {{16{sgn & m[7]}},  m[7:0],   m[15:8]};
      MASK_HALF_HI: r = {{16{sgn & m[23]}}, m[23:16], m[31:24]};
      MASK_BYTE0:   r = {{24{sgn & m[7]}},  m[7:0]};
      MASK_BYTE1:   r = {{24{sgn & m[15]}}, m[15:8]};
      MASK_BYTE2:   r = {{24{sgn & m[23]}}, m[23:16]};
      default:      r = {{24{sgn & m[31]}}, m[31:24]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_req_fifo.sv
// In-order queue of outstanding load requests.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i, wr_data_i  enqueue (ignored when full)
//   pop_i              dequeue head (ignored when empty)
//   rd_data_o          current head entry
//   count_o            number of stored entries (P_DEPTH_W+1 bits)
//   full_o, empty_o    registered-count status flags
module load_req_fifo
  import mist1032sa_mem_pkg::*;
#(
  parameter int P_WIDTH   = 9,
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [P_WIDTH-1:0]   wr_data_i,
  input  logic                 pop_i,
  output logic [P_WIDTH-1:0]   rd_data_o,
  output logic [P_DEPTH_W:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam logic [P_DEPTH_W:0] LP_FULL = P_DEPTH[P_DEPTH_W:0];

  logic [P_WIDTH-1:0]   mem_q [P_DEPTH];
  logic [P_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_DEPTH_W:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o    = (count_q == LP_FULL);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/load_endian_aligner.sv
// Load-path endian aligner: queues load requests in order, pairs each
// big-endian memory response with the oldest request, and returns the
// right-aligned, extended value with its tag.
// Optional feature macro: MIST1032SA_LOAD_SIGNEXT_EN
//   defined   - iREQ_SIGNED is queued and selects sign extension
//   undefined - iREQ_SIGNED is ignored; byte/halfword results zero-extend
// Ports:
//   iCLOCK, inRESET_SYNC                 clock, synchronous active-low reset
//   iREQ_VALID/oREQ_BUSY                 request handshake
//   iREQ_MASK, iREQ_SIGNED, iREQ_TAG     request attributes
//   iMEM_VALID/oMEM_BUSY, iMEM_DATA      memory response handshake and word
//   oLOAD_VALID/iLOAD_BUSY               result handshake
//   oLOAD_DATA, oLOAD_TAG                result value and tag
//   oOUTSTANDING                         queued request count
//   oERROR                               sticky: response with empty queue
module load_endian_aligner
  import mist1032sa_mem_pkg::*;
#(
  parameter int P_TAG_W   = 5,
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_W = 2
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET_SYNC,
  input  logic                 iREQ_VALID,
  output logic                 oREQ_BUSY,
  input  logic [3:0]           iREQ_MASK,
  input  logic                 iREQ_SIGNED,
  input  logic [P_TAG_W-1:0]   iREQ_TAG,
  input  logic                 iMEM_VALID,
  output logic                 oMEM_BUSY,
  input  logic [31:0]          iMEM_DATA,
  output logic                 oLOAD_VALID,
  input  logic                 iLOAD_BUSY,
  output logic [31:0]          oLOAD_DATA,
  output logic [P_TAG_W-1:0]   oLOAD_TAG,
  output logic [P_DEPTH_W:0]   oOUTSTANDING,
  output logic                 oERROR
);

`ifdef MIST1032SA_LOAD_SIGNEXT_EN
  localparam int LP_ATTR_W = 5;
`else
  localparam int LP_ATTR_W = 4;
`endif
  localparam int LP_ENTRY_W = LP_ATTR_W + P_TAG_W;

  logic [LP_ENTRY_W-1:0] wr_entry, head_entry;
  logic [3:0]            head_mask;
  logic                  head_sgn;
  logic [P_TAG_W-1:0]    head_tag;
  logic                  q_full, q_empty;
  logic                  req_accept, mem_accept, pop;

  logic                  valid_q, valid_d;
  logic [31:0]           data_q, data_d;
  logic [P_TAG_W-1:0]    tag_q, tag_d;
  logic                  err_q, err_d;

`ifdef MIST1032SA_LOAD_SIGNEXT_EN
  ld_attr_t push_attr;
  assign push_attr = '{mask: iREQ_MASK, sgn: iREQ_SIGNED};
  assign wr_entry  = {push_attr, iREQ_TAG};
  assign head_sgn  = head_entry[P_TAG_W];
`else
  logic unused_req_signed;
  assign unused_req_signed = iREQ_SIGNED;
  assign wr_entry  = {iREQ_MASK, iREQ_TAG};
  assign head_sgn  = 1'b0;
`endif
  assign head_mask = head_entry[LP_ENTRY_W-1 -: 4];
  assign head_tag  = head_entry[P_TAG_W-1:0];

  assign oREQ_BUSY  = q_full;
  assign oMEM_BUSY  = valid_q && iLOAD_BUSY;
  assign req_accept = iREQ_VALID && !q_full;
  assign mem_accept = iMEM_VALID && !oMEM_BUSY;
  // Emptiness is taken from the registered count, so a same-cycle push can
  // never satisfy a response.
  assign pop        = mem_accept && !q_empty;

  load_req_fifo #(
    .P_WIDTH   (LP_ENTRY_W),
    .P_DEPTH   (P_DEPTH),
    .P_DEPTH_W (P_DEPTH_W)
  ) u_req_fifo (
    .clk_i     (iCLOCK),
    .rst_ni    (inRESET_SYNC),
    .push_i    (req_accept),
    .wr_data_i (wr_entry),
    .pop_i     (pop),
    .rd_data_o (head_entry),
    .count_o   (oOUTSTANDING),
    .full_o    (q_full),
    .empty_o   (q_empty)
  );

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    err_d   = err_q;
    if (pop) begin
      valid_d = 1'b1;
      data_d  = ld_align(head_mask, head_sgn, iMEM_DATA);
      tag_d   = head_tag;
    end else if (valid_q && !iLOAD_BUSY) begin
      valid_d = 1'b0;
      data_d  = '0;
      tag_d   = '0;
    end
    if (mem_accept && q_empty) err_d = 1'b1;
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET_SYNC) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign oLOAD_VALID = valid_q;
  assign oLOAD_DATA  = data_q;
  assign oLOAD_TAG   = tag_q;
  assign oERROR      = err_q;

endmodule

// File: tb/tb_load_endian_aligner.sv
module tb_load_endian_aligner;
  import mist1032sa_mem_pkg::*;

  logic        iCLOCK = 1'b0;
  logic        inRESET_SYNC;
  logic        iREQ_VALID;
  logic        oREQ_BUSY;
  logic [3:0]  iREQ_MASK;
  logic        iREQ_SIGNED;
  logic [4:0]  iREQ_TAG;
  logic        iMEM_VALID;
  logic        oMEM_BUSY;
  logic [31:0] iMEM_DATA;
  logic        oLOAD_VALID;
  logic        iLOAD_BUSY;
  logic [31:0] oLOAD_DATA;
  logic [4:0]  oLOAD_TAG;
  logic [2:0]  oOUTSTANDING;
  logic        oERROR;

  int checks = 0;
  int errors = 0;

  load_endian_aligner #(.P_TAG_W(5), .P_DEPTH(4), .P_DEPTH_W(2)) dut (
    .iCLOCK       (iCLOCK),
    .inRESET_SYNC (inRESET_SYNC),
    .iREQ_VALID   (iREQ_VALID),
    .oREQ_BUSY    (oREQ_BUSY),
    .iREQ_MASK    (iREQ_MASK),
    .iREQ_SIGNED  (iREQ_SIGNED),
    .iREQ_TAG     (iREQ_TAG),
    .iMEM_VALID   (iMEM_VALID),
    .oMEM_BUSY    (oMEM_BUSY),
    .iMEM_DATA    (iMEM_DATA),
    .oLOAD_VALID  (oLOAD_VALID),
    .iLOAD_BUSY   (iLOAD_BUSY),
    .oLOAD_DATA   (oLOAD_DATA),
    .oLOAD_TAG    (oLOAD_TAG),
    .oOUTSTANDING (oOUTSTANDING),
    .oERROR       (oERROR)
  );

  always #5 iCLOCK = ~iCLOCK;

  // Stimulus is applied and outputs sampled on the falling edge.
  task automatic push(input logic [3:0] mask, input logic sgn, input logic [4:0] tag);
    iREQ_VALID  = 1'b1;
    iREQ_MASK   = mask;
    iREQ_SIGNED = sgn;
    iREQ_TAG    = tag;
    @(posedge iCLOCK);
    @(negedge iCLOCK);
    iREQ_VALID  = 1'b0;
  endtask

  task automatic resp(input logic [31:0] data);
    iMEM_VALID = 1'b1;
    iMEM_DATA  = data;
    @(posedge iCLOCK);
    @(negedge iCLOCK);
    iMEM_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLOCK);
      @(negedge iCLOCK);
    end
  endtask

  task automatic test_reset;
    inRESET_SYNC = 1'b0;
    idle(2);
    checks++;
    if (oLOAD_VALID !== 1'b0 || oLOAD_DATA !== 32'h0 || oLOAD_TAG !== 5'd0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h tag=%0d required 0/0/0", oLOAD_VALID, oLOAD_DATA, oLOAD_TAG);
    end
    checks++;
    if (oOUTSTANDING !== 3'd0 || oERROR !== 1'b0 || oREQ_BUSY !== 1'b0 || oMEM_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: outst=%0d err=%b rbusy=%b mbusy=%b required 0/0/0/0", oOUTSTANDING, oERROR, oREQ_BUSY, oMEM_BUSY);
    end
    inRESET_SYNC = 1'b1;
    idle(1);
  endtask

  task automatic test_word;
    push(MASK_WORD, 1'b0, 5'd3);
    checks++;
    if (oOUTSTANDING !== 3'd1) begin
      errors++;
      $display("FAIL word_outst: got %0d required 1", oOUTSTANDING);
    end
    resp(32'h11223344);
    checks++;
    if (oLOAD_VALID !== 1'b1 || oLOAD_DATA !== 32'h44332211 || oLOAD_TAG !== 5'd3) begin
      errors++;
      $display("FAIL word_load: valid=%b data=%h tag=%0d required 1/44332211/3", oLOAD_VALID, oLOAD_DATA, oLOAD_TAG);
    end
    idle(1);
    checks++;
    if (oLOAD_VALID !== 1'b0 || oOUTSTANDING !== 3'd0) begin
      errors++;
      $display("FAIL word_drain: valid=%b outst=%0d required 0/0", oLOAD_VALID, oOUTSTANDING);
    end
  endtask

  task automatic test_half_signed;
    logic [31:0] exp_hi, exp_b0;
`ifdef MIST1032SA_LOAD_SIGNEXT_EN
    exp_hi = 32'hFFFFFF80;
    exp_b0 = 32'hFFFFFF80;
`else
    exp_hi = 32'h0000FF80;
    exp_b0 = 32'h00000080;
`endif
    push(MASK_HALF_HI, 1'b1, 5'd7);
    resp(32'h80FF0000);
    checks++;
    if (oLOAD_DATA !== exp_hi || oLOAD_TAG !== 5'd7) begin
      errors++;
      $display("FAIL half_hi_signed: data=%h tag=%0d required %h/7", oLOAD_DATA, oLOAD_TAG, exp_hi);
    end
    push(MASK_HALF_LO, 1'b0, 5'd8);
    resp(32'h11228899);
    checks++;
    if (oLOAD_DATA !== 32'h00009988 || oLOAD_TAG !== 5'd8) begin
      errors++;
      $display("FAIL half_lo_unsigned: data=%h tag=%0d required 00009988/8", oLOAD_DATA, oLOAD_TAG);
    end
    push(MASK_BYTE0, 1'b1, 5'd9);
    resp(32'h00000080);
    checks++;
    if (oLOAD_DATA !== exp_b0) begin
      errors++;
      $display("FAIL byte0_signed: data=%h required %h", oLOAD_DATA, exp_b0);
    end
    idle(1);
  endtask

  task automatic test_bytes;
    logic [3:0]  masks [5];
    logic [31:0] exps  [5];
    masks = '{MASK_BYTE0, MASK_BYTE1, MASK_BYTE2, MASK_BYTE3, 4'b0101};
    exps  = '{32'hDD, 32'hCC, 32'hBB, 32'hAA, 32'hAA};
    for (int i = 0; i < 5; i++) begin
      push(masks[i], 1'b0, 5'(i + 16));
      resp(32'hAABBCCDD);
      checks++;
      if (oLOAD_VALID !== 1'b1 || oLOAD_DATA !== exps[i] || oLOAD_TAG !== 5'(i + 16)) begin
        errors++;
        $display("FAIL byte_lane[%0d]: valid=%b data=%h tag=%0d required 1/%h/%0d", i, oLOAD_VALID, oLOAD_DATA, oLOAD_TAG, exps[i], i + 16);
      end
    end
    idle(1);
  endtask

  task automatic test_full;
    for (int i = 1; i <= 4; i++) push(MASK_WORD, 1'b0, 5'(i));
    checks++;
    if (oREQ_BUSY !== 1'b1 || oOUTSTANDING !== 3'd4) begin
      errors++;
      $display("FAIL full_flag: rbusy=%b outst=%0d required 1/4", oREQ_BUSY, oOUTSTANDING);
    end
    push(MASK_WORD, 1'b0, 5'd9);
    checks++;
    if (oOUTSTANDING !== 3'd4) begin
      errors++;
      $display("FAIL full_ignore: outst=%0d required 4", oOUTSTANDING);
    end
    resp(32'h01020304);
    checks++;
    if (oREQ_BUSY !== 1'b0 || oOUTSTANDING !== 3'd3 || oLOAD_TAG !== 5'd1 || oLOAD_DATA !== 32'h04030201) begin
      errors++;
      $display("FAIL full_pop: rbusy=%b outst=%0d tag=%0d data=%h required 0/3/1/04030201", oREQ_BUSY, oOUTSTANDING, oLOAD_TAG, oLOAD_DATA);
    end
    for (int i = 2; i <= 4; i++) begin
      resp(32'h0);
      checks++;
      if (oLOAD_TAG !== 5'(i)) begin
        errors++;
        $display("FAIL full_order[%0d]: tag=%0d required %0d", i, oLOAD_TAG, i);
      end
    end
    idle(1);
    checks++;
    if (oOUTSTANDING !== 3'd0 || oLOAD_VALID !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: outst=%0d valid=%b required 0/0", oOUTSTANDING, oLOAD_VALID);
    end
  endtask

  task automatic test_backpressure;
    push(MASK_BYTE0, 1'b0, 5'd5);
    push(MASK_BYTE0, 1'b0, 5'd6);
    push(MASK_BYTE0, 1'b0, 5'd7);
    iLOAD_BUSY = 1'b1;
    resp(32'h00000005);
    iMEM_VALID = 1'b1;
    iMEM_DATA  = 32'h00000006;
    checks++;
    if (oLOAD_DATA !== 32'h5 || oLOAD_TAG !== 5'd5 || oMEM_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: data=%h tag=%0d mbusy=%b required 5/5/1", oLOAD_DATA, oLOAD_TAG, oMEM_BUSY);
    end
    for (int c = 0; c < 5; c++) begin
      idle(1);
      checks++;
      if (oLOAD_VALID !== 1'b1 || oLOAD_DATA !== 32'h5 || oLOAD_TAG !== 5'd5 ||
          oMEM_BUSY !== 1'b1 || oOUTSTANDING !== 3'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h tag=%0d mbusy=%b outst=%0d required 1/5/5/1/2",
                 c, oLOAD_VALID, oLOAD_DATA, oLOAD_TAG, oMEM_BUSY, oOUTSTANDING);
      end
    end
    iLOAD_BUSY = 1'b0;
    idle(1);
    checks++;
    if (oLOAD_VALID !== 1'b1 || oLOAD_DATA !== 32'h6 || oLOAD_TAG !== 5'd6 || oOUTSTANDING !== 3'd1) begin
      errors++;
      $display("FAIL bp_release: valid=%b data=%h tag=%0d outst=%0d required 1/6/6/1", oLOAD_VALID, oLOAD_DATA, oLOAD_TAG, oOUTSTANDING);
    end
    iMEM_DATA = 32'h00000007;
    idle(1);
    iMEM_VALID = 1'b0;
    checks++;
    if (oLOAD_DATA !== 32'h7 || oLOAD_TAG !== 5'd7 || oOUTSTANDING !== 3'd0) begin
      errors++;
      $display("FAIL bp_next: data=%h tag=%0d outst=%0d required 7/7/0", oLOAD_DATA, oLOAD_TAG, oOUTSTANDING);
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    push(MASK_WORD, 1'b0, 5'd10);
    iREQ_VALID = 1'b1;
    iREQ_MASK  = MASK_HALF_LO;
    iREQ_TAG   = 5'd11;
    iMEM_VALID = 1'b1;
    iMEM_DATA  = 32'hA1B2C3D4;
    idle(1);
    iREQ_VALID = 1'b0;
    iMEM_VALID = 1'b0;
    checks++;
    if (oOUTSTANDING !== 3'd1 || oLOAD_TAG !== 5'd10 || oLOAD_DATA !== 32'hD4C3B2A1) begin
      errors++;
      $display("FAIL b2b_pushpop: outst=%0d tag=%0d data=%h required 1/10/d4c3b2a1", oOUTSTANDING, oLOAD_TAG, oLOAD_DATA);
    end
    resp(32'h0000BEEF);
    checks++;
    if (oLOAD_TAG !== 5'd11 || oLOAD_DATA !== 32'h0000EFBE || oOUTSTANDING !== 3'd0) begin
      errors++;
      $display("FAIL b2b_second: tag=%0d data=%h outst=%0d required 11/0000efbe/0", oLOAD_TAG, oLOAD_DATA, oOUTSTANDING);
    end
    idle(1);
  endtask

  task automatic test_error_reset;
    resp(32'h12345678);
    checks++;
    if (oLOAD_VALID !== 1'b0 || oERROR !== 1'b1) begin
      errors++;
      $display("FAIL err_empty: valid=%b err=%b required 0/1", oLOAD_VALID, oERROR);
    end
    push(MASK_WORD, 1'b0, 5'd1);
    push(MASK_WORD, 1'b0, 5'd2);
    push(MASK_WORD, 1'b0, 5'd3);
    iLOAD_BUSY = 1'b1;
    resp(32'h0);
    checks++;
    if (oERROR !== 1'b1 || oOUTSTANDING !== 3'd2 || oLOAD_VALID !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b outst=%0d valid=%b required 1/2/1", oERROR, oOUTSTANDING, oLOAD_VALID);
    end
    inRESET_SYNC = 1'b0;
    idle(1);
    checks++;
    if (oOUTSTANDING !== 3'd0 || oLOAD_VALID !== 1'b0 || oERROR !== 1'b0 || oLOAD_DATA !== 32'h0) begin
      errors++;
      $display("FAIL err_reset: outst=%0d valid=%b err=%b data=%h required 0/0/0/0", oOUTSTANDING, oLOAD_VALID, oERROR, oLOAD_DATA);
    end
    inRESET_SYNC = 1'b1;
    iLOAD_BUSY   = 1'b0;
    idle(1);
  endtask

  initial begin
    inRESET_SYNC = 1'b0;
    iREQ_VALID   = 1'b0;
    iREQ_MASK    = 4'b0;
    iREQ_SIGNED  = 1'b0;
    iREQ_TAG     = 5'd0;
    iMEM_VALID   = 1'b0;
    iMEM_DATA    = 32'h0;
    iLOAD_BUSY   = 1'b0;
    @(negedge iCLOCK);
    test_reset;
    test_word;
    test_half_signed;
    test_bytes;
    test_full;
    test_backpressure;
    test_back_to_back;
    test_error_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
